ff_preset_ctrl: RTL

//   Drives the active-low async reset/set pins of a bank of set/reset flops
//   so the bank loads a requested pattern without a clock edge on the bank.
//   The bank takes R/S and holds Q; this block generates R/S. It owns pulse

---
 rtl/ff_preset_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/ff_preset_ctrl.sv
// rtl/ff_preset_ctrl.sv - async set/reset pulse generator that loads a flop bank pattern and checks readback
module ff_preset_ctrl #(
  parameter int WIDTH       = 8,
  parameter int PULSE_CYC   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             R,
  input  logic             req,
  input  logic [WIDTH-1:0] val,
  input  logic [WIDTH-1:0] q_chk,
  output logic [WIDTH-1:0] rn,
  output logic [WIDTH-1:0] sn,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CMAX = (PULSE_CYC > SYNC_STAGES) ? PULSE_CYC : SYNC_STAGES;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] S_LAST = CW'(SYNC_STAGES - 1);

  localparam logic [2:0] RST_REL = 3'd0;
  localparam logic [2:0] IDLE    = 3'd1;
  localparam logic [2:0] ASSERT  = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] CHECK   = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] val_q;

  // rn/sn are always complementary or both high, so no bit ever sees R and S low together.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state <= RST_REL;
      cnt   <= '0;
      val_q <= '0;
      rn    <= '0;
      sn    <= '1;
      busy  <= 1'b1;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RST_REL: begin
          rn <= '1;
          sn <= '1;
          if (cnt == S_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          busy <= 1'b0;
          rn   <= '1;
          sn   <= '1;
          if (req) begin
            val_q <= val;
            rn    <= val;
            sn    <= ~val;
            state <= ASSERT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ASSERT: begin
          if (cnt == P_LAST) begin
            rn    <= '1;
            sn    <= '1;
            state <= RELEASE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == S_LAST) begin
            state <= CHECK;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          err   <= (q_chk != val_q);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          rn    <= '1;
          sn    <= '1;
          busy  <= 1'b1;
          state <= RST_REL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
